// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation encodings and FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;
  localparam logic [3:0] ALU_DIVU  = 4'b1100;
  localparam logic [3:0] ALU_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [3:0] sel);
    return sel inside {ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU};
  endfunction

endpackage

// File: rtl/n_bit_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
module n_bit_iter_muldiv #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] lo,
  output logic [N-1:0] hi,
  output logic         last
);

  localparam int CW = $clog2(N) + 1;

  logic [N-1:0]  hi_reg, lo_reg, b_reg;
  logic          div_reg, sel_hi_reg;
  logic [CW-1:0] count_reg;

  logic [N-1:0] hi_next, lo_next;
  logic [N:0]   mul_sum;
  logic [N:0]   rem_shift;

  always_comb begin
    hi_next   = hi_reg;
    lo_next   = lo_reg;
    mul_sum   = {1'b0, hi_reg} + {1'b0, (lo_reg[0] ? b_reg : {N{1'b0}})};
    rem_shift = {hi_reg, lo_reg[N-1]};
    if (div_reg) begin
      // Compare at N+1 bits so a zero divisor always "fits": quotient all ones, remainder A.
      if (rem_shift >= {1'b0, b_reg}) begin
        hi_next = rem_shift[N-1:0] - b_reg;
        lo_next = {lo_reg[N-2:0], 1'b1};
      end else begin
        hi_next = rem_shift[N-1:0];
        lo_next = {lo_reg[N-2:0], 1'b0};
      end
    end else begin
      hi_next = mul_sum[N:1];
      lo_next = {mul_sum[0], lo_reg[N-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg     <= '0;
      lo_reg     <= '0;
      b_reg      <= '0;
      div_reg    <= 1'b0;
      sel_hi_reg <= 1'b0;
      count_reg  <= '0;
    end else if (load) begin
      hi_reg     <= '0;
      lo_reg     <= A;
      b_reg      <= B;
      div_reg    <= op[1];
      sel_hi_reg <= op[0];
      count_reg  <= CW'(N);
    end else if (count_reg != '0) begin
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      count_reg <= count_reg - CW'(1);
    end
  end

  // Outputs show the value after this cycle's step; only the requested half is driven,
  // so the parent can merge the two with a plain OR on the last step.
  assign last = (count_reg == CW'(1));
  assign hi   = sel_hi_reg ? hi_next : '0;
  assign lo   = sel_hi_reg ? '0 : lo_next;

endmodule

// File: rtl/rca.sv
// N-bit ripple-carry adder built from a chain of full adders.
module rca #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum
);

  logic [N-1:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_fa
      assign sum[gi] = a[gi] ^ b[gi] ^ carry[gi];
      // The carry out of the top bit is never consumed, so it is not built.
      if (gi < N - 1) begin : g_carry
        assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
      end
    end
  endgenerate

endmodule

// File: rtl/n_bit_seq_alu.sv
// Execute-stage ALU with start/busy/done handshake; iterative mul/div, single-cycle everything else.
module n_bit_seq_alu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   sel,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] ALUOutput,
  output logic         zeroFlag
);

  localparam int SW = $clog2(N);

  state_t       state_reg;
  logic         is_sub;
  logic [N-1:0] rca_b, rca_sum;
  logic [SW-1:0] sh;
  logic [N-1:0] single_result;
  logic         load;
  logic [N-1:0] md_lo, md_hi;
  logic         md_last;

  assign is_sub = (sel == ALU_SUB);
  assign rca_b  = is_sub ? ~B : B;
  assign sh     = B[SW-1:0];
  assign load   = (state_reg == IDLE) && start && is_iterative(sel);

  rca #(.N(N)) u_rca (
    .a   (A),
    .b   (rca_b),
    .cin (is_sub),
    .sum (rca_sum)
  );

  n_bit_iter_muldiv #(.N(N)) u_muldiv (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .op   ({sel[2], sel[0]}),
    .A    (A),
    .B    (B),
    .lo   (md_lo),
    .hi   (md_hi),
    .last (md_last)
  );

  always_comb begin
    single_result = '0;
    case (sel)
      ALU_ADD,
      ALU_SUB:  single_result = rca_sum;
      ALU_AND:  single_result = A & B;
      ALU_OR:   single_result = A | B;
      ALU_XOR:  single_result = A ^ B;
      ALU_SLL:  single_result = A << sh;
      ALU_SRL:  single_result = A >> sh;
      ALU_SRA:  single_result = $signed(A) >>> sh;
      ALU_SLT:  single_result = {{(N-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: single_result = {{(N-1){1'b0}}, (A < B)};
      default:  single_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ALUOutput <= '0;
      zeroFlag  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (is_iterative(sel)) begin
              state_reg <= RUN;
            end else begin
              ALUOutput <= single_result;
              zeroFlag  <= (single_result == '0);
              done      <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        RUN: begin
          if (md_last) begin
            ALUOutput <= md_lo | md_hi;
            zeroFlag  <= ((md_lo | md_hi) == '0);
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n_bit_seq_alu.sv
// Directed bench for n_bit_seq_alu with a cycle-level reference model and per-cycle output checks.
module tb_n_bit_seq_alu;
  import alu_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic [3:0]   sel = '0;
  logic         busy, done, zeroFlag;
  logic [N-1:0] ALUOutput;

  n_bit_seq_alu #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .ALUOutput (ALUOutput),
    .zeroFlag  (zeroFlag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Issued-operation record (written by the driver) and model output state (written by the checker).
  int           issue_id = 0;
  int           retired_id = 0;
  int           acc_c = 0;
  int           done_c = 0;
  int           next_ok = 0;
  int           rst_edge = -1;
  int           want_lat = 0;
  logic [N-1:0] res = '0;
  logic [N-1:0] lit = '0;
  logic [N-1:0] exp_out = '0;
  bit           checking = 1'b0;

  function automatic logic [N-1:0] model(input logic [3:0] s, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] p;
    int sh;
    p  = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    sh = int'(b[$clog2(N)-1:0]);
    case (s)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLL:   return a << sh;
      ALU_SRL:   return a >> sh;
      ALU_SRA:   return $signed(a) >>> sh;
      ALU_SLT:   return ($signed(a) < $signed(b)) ? N'(1) : N'(0);
      ALU_SLTU:  return (a < b) ? N'(1) : N'(0);
      ALU_MUL:   return p[N-1:0];
      ALU_MULHU: return p[2*N-1:N];
      ALU_DIVU:  if (b == '0) return '1; else return a / b;
      ALU_REMU:  if (b == '0) return a;  else return a % b;
      default:   return '0;
    endcase
  endfunction

  function automatic int lat(input logic [3:0] s);
    return (s == ALU_MUL || s == ALU_MULHU || s == ALU_DIVU || s == ALU_REMU) ? N : 0;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Compare process: every cycle after the initial reset, all four outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      bit active, exp_done, exp_busy;
      if (cyc == rst_edge) begin
        retired_id = issue_id;
        exp_out    = '0;
      end
      active   = (issue_id != retired_id);
      exp_done = active && (cyc == done_c);
      exp_busy = active && (cyc >= acc_c) && (cyc <= done_c);
      if (exp_done) exp_out = res;
      chk("done", N'(done), N'(exp_done));
      chk("busy", N'(busy), N'(exp_busy));
      chk("ALUOutput", ALUOutput, exp_out);
      chk("zeroFlag", N'(zeroFlag), N'(exp_out == '0));
      if (exp_done) begin
        chk("literal", ALUOutput, lit);
        $display("[TB] op done cyc=%0d result=%h expected=%h", cyc, ALUOutput, lit);
        retired_id = issue_id;
      end
      if (done === 1'b1 && want_lat != 0) chk("latency", N'(cyc - acc_c + 1), N'(want_lat));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] s, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] l, input int wl);
    while (cyc < next_ok) tick();
    start    = 1'b1;
    sel      = s;
    A        = a;
    B        = b;
    acc_c    = cyc + 1;
    done_c   = acc_c + lat(s);
    res      = model(s, a, b);
    lit      = l;
    want_lat = wl;
    next_ok  = done_c + 1;
    issue_id++;
    tick();
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    sel   = 4'($urandom);
  endtask

  task automatic pulse_ignored(input logic [3:0] s, input logic [N-1:0] a, input logic [N-1:0] b);
    start = 1'b1;
    sel   = s;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
  endtask

  task automatic reset_pulse();
    rst      = 1'b1;
    start    = 1'b1;
    sel      = ALU_ADD;
    rst_edge = cyc + 1;
    next_ok  = cyc + 2;
    tick();
    rst   = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst      = 1'b0;
    checking = 1'b1;
    repeat (2) tick();

    issue(ALU_SUB,   32'd5,        32'd5,        32'h0000_0000, 0);
    issue(ALU_SRA,   32'h8000_0000, 32'h24,      32'hF800_0000, 0);
    issue(ALU_SLT,   32'hFFFF_FFFF, 32'd1,       32'h0000_0001, 0);
    issue(ALU_SLTU,  32'hFFFF_FFFF, 32'd1,       32'h0000_0000, 0);
    issue(ALU_ADD,   32'hFFFF_FFFF, 32'd1,       32'h0000_0000, 0);
    issue(ALU_ADD,   32'd3,        32'd4,        32'd7,         0);
    issue(ALU_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0);
    issue(ALU_OR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0);
    issue(ALU_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
    issue(ALU_SLL,   32'd1,        32'd31,       32'h8000_0000, 0);
    issue(ALU_SRL,   32'h8000_0000, 32'h21,      32'h4000_0000, 0);
    issue(4'b1110,   32'd123,      32'd456,      32'h0000_0000, 0);
    issue(ALU_MUL,   32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFE, 33);
    issue(ALU_MULHU, 32'hFFFF_FFFF, 32'd2,       32'h0000_0001, 33);
    issue(ALU_MUL,   32'd12345,    32'd678,      32'd8369910,   0);
    issue(ALU_DIVU,  32'd100,      32'd7,        32'd14,        0);
    issue(ALU_REMU,  32'd100,      32'd7,        32'd2,         0);
    issue(ALU_DIVU,  32'd9,        32'd0,        32'hFFFF_FFFF, 0);
    issue(ALU_REMU,  32'd9,        32'd0,        32'd9,         0);

    // Add pulsed in the middle of a divide must be dropped.
    issue(ALU_DIVU,  32'd1000,     32'd10,       32'd100,       0);
    repeat (5) tick();
    pulse_ignored(ALU_ADD, 32'd1, 32'd1);

    // Reset in cycle 10 of a multiply: no done, idle afterwards.
    issue(ALU_MUL,   32'd7,        32'd9,        32'd63,        0);
    while (cyc < acc_c + 9) tick();
    reset_pulse();
    repeat (40) tick();

    issue(ALU_SUB,   32'd10,       32'd3,        32'd7,         0);
    while (cyc < next_ok + 2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/n_bit_seq_alu.md
# n_bit_seq_alu

Parametrised N-bit execute-stage ALU, the successor to the combinational add/sub/and/or ALU. It keeps that unit's select encodings and adds xor, shifts, set-less-than and unsigned multiply/divide/remainder. All results are registered behind a start/done handshake, so the pipeline stalls on `busy`. Single-cycle ops complete in 1 cycle; multiply and divide iterate for N cycles.

## Interface
- `N`, 32, operand/result width; power of two, ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `A`  in  N  operand A, captured on an accepted start.
- `B`  in  N  operand B, captured on an accepted start.
- `sel`  in  4  operation, captured on an accepted start.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; result valid.
- `ALUOutput`  out  N  registered result, held until the next `done`.
- `zeroFlag`  out  1  registered; high when `ALUOutput` == 0.

## Operation
- Encodings:
  - 0010 add, 0110 sub (A + ~B + 1), 0000 and, 0001 or, 0011 xor.
  - 0100 sll, 0101 srl, 0111 sra. Shift amount is `B[log2(N)-1:0]`; upper bits of B are ignored.
  - 1000 slt (signed), 1001 sltu. Result is 1 or 0, zero-extended.
  - 1010 mul: low N bits of the unsigned product.
  - 1011 mulhu: high N bits of the unsigned product.
  - 1100 divu, 1101 remu.
  - Any other code: result 0, single-cycle path.
- Add/sub wrap modulo 2^N. No carry or overflow output.
- Divide by zero: divu returns all-ones; remu returns A. No exception is raised.
- FSM states:
  - IDLE: on `start`, capture A, B and sel. Go to RUN for mul/mulhu/divu/remu, otherwise compute and go to DONE.
  - RUN: one iteration per cycle. A log2(N)+1-bit counter counts down from N. At 0, go to DONE.
  - DONE: assert `done`, update `ALUOutput`/`zeroFlag`, then go to IDLE.
- Multiply uses shift-add on a 2N-bit accumulator: if the multiplier LSB is set, add the multiplicand into the upper half, then shift right 1.
- Divide uses restoring division: shift the {rem, quot} pair left, trial-subtract the divisor, set the quotient bit when the difference is non-negative.
- `start` in RUN or DONE is ignored, not queued. Inputs may change freely after acceptance.
- `rst` overrides everything, including mid-RUN. It aborts the operation with no `done`.
- Reset values:
  - state IDLE, `busy` 0, `done` 0
  - `ALUOutput` 0, `zeroFlag` 1
  - counter 0, internal accumulators 0

## Timing
- Start accepted at edge k:
  - Single-cycle op: `done`/result visible in cycle k+1. Next start can be accepted at edge k+2.
  - Mul/div: `busy` is high cycles k+1 … k+N+1, `done` is high in cycle k+N+1. Total N+1-cycle latency.
- `done` is high for exactly one cycle per accepted start.
- `zeroFlag` and `ALUOutput` change only on the edge that enters DONE.
- `rst` asserted at edge r: all outputs take their reset values in cycle r+1, and `start` is ignored while `rst` is high.

## Structure
- Shared package `alu_pkg` holds:
  - the `sel` encoding localparams (names ALU_ADD, ALU_SUB, …), shared with the control unit;
  - the FSM state type (IDLE/RUN/DONE).
- Existing `rca` is reused for add/sub.
- One sub-module: `n_bit_iter_muldiv`. It contains the accumulator, counter and per-cycle mul/div step. Its interface is load, op[1:0], A, B, and outputs lo, hi, last.
- The parent keeps the FSM, the single-cycle result mux and the output registers.

## Test plan
- Reset mid-RUN:
  - Reset, then release: `ALUOutput`=0, `zeroFlag`=1, `busy`=0.
  - Start mul, assert `rst` at cycle 10: no `done`, state IDLE next cycle.
- Start sub A=5, B=5 → `done` in cycle k+1, `ALUOutput`=0, `zeroFlag`=1. Then sra A=0x80000000, B=0x24 (shift 4) → 0xF8000000.
- slt A=0xFFFFFFFF, B=1 → 1. sltu with the same operands → 0.
- mul A=0xFFFFFFFF, B=2 → `done` exactly 33 cycles after acceptance, result 0xFFFFFFFE. mulhu with the same operands → 1.
- divu A=100, B=7 → 14. remu → 2. divu A=9, B=0 → 0xFFFFFFFF. remu A=9, B=0 → 9.
- Pulse `start` with add during RUN of a divu → ignored. Only one `done`, carrying the divu result.
